// File: rtl/adc_avg_filter.sv
// adc_avg_filter: paces SAR conversions, captures each result on a fresh
// end-of-conversion edge and outputs a moving average over the last
// 2^LOG2_DEPTH samples.
// Optional feature macro: ADC_MINMAX_EN adds min_val/max_val peak-hold outputs.
module adc_avg_filter #(
  parameter int WIDTH        = 8,
  parameter int LOG2_DEPTH   = 3,
  parameter int PERIOD       = 50000,  // must be >= 2
  parameter int START_CYCLES = 4,      // must be >= 1
  parameter int TIMEOUT      = 65535   // must be >= 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] adc_value,
  input  logic             adc_eoc,
  output logic             adc_start,
  output logic [WIDTH-1:0] avg,
  output logic             avg_valid,
  output logic             sample_strobe,
  output logic             timeout_err
`ifdef ADC_MINMAX_EN
  , output logic [WIDTH-1:0] min_val
  , output logic [WIDTH-1:0] max_val
`endif
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SUM_W = WIDTH + LOG2_DEPTH;
  localparam int TMAX  = (TIMEOUT > PERIOD)
                         ? ((TIMEOUT > START_CYCLES) ? TIMEOUT : START_CYCLES)
                         : ((PERIOD  > START_CYCLES) ? PERIOD  : START_CYCLES);
  localparam int TW    = $clog2(TMAX + 1);

  localparam logic [TW-1:0]         START_LAST   = TW'(START_CYCLES - 1);
  localparam logic [TW-1:0]         TIMEOUT_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]         WAIT_LAST    = TW'(PERIOD - 2);
  localparam logic [LOG2_DEPTH:0]   FILL_FULL    = (LOG2_DEPTH + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_START, S_CONVERT, S_ACCUM
  } state_t;

  // Floor division of the window sum by the window length.
  function automatic logic [WIDTH-1:0] f_avg(input logic [SUM_W-1:0] s);
    return s[SUM_W-1:LOG2_DEPTH];
  endfunction

  state_t              r_state;
  logic [TW-1:0]       r_timer;
  logic                r_start;
  logic                r_timeout_err;
  logic                r_eoc_prev;
  logic                w_eoc_rise;
  logic                w_capture;

  logic [WIDTH-1:0]      r_sample_p0;
  logic [SUM_W-1:0]      r_sum_p1;
  logic [LOG2_DEPTH-1:0] r_wr_ptr;
  logic [LOG2_DEPTH:0]   r_fill;
  logic [WIDTH-1:0]      r_buf [DEPTH];
  logic                  r_strobe_p1;
  logic [WIDTH-1:0]      r_avg_p2;
  logic                  r_vld_p2;

  // A stale high eoc on CONVERT entry is ignored: only a 0->1 edge counts.
  assign w_eoc_rise = adc_eoc & ~r_eoc_prev;
  assign w_capture  = (r_state == S_CONVERT) && w_eoc_rise;

  // Conversion sequencer: request pacing, eoc wait with timeout, window update.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_timer       <= '0;
      r_start       <= 1'b0;
      r_timeout_err <= 1'b0;
      r_eoc_prev    <= 1'b0;
    end else begin
      r_eoc_prev <= adc_eoc;
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_state <= S_START;
            r_start <= 1'b1;
            r_timer <= '0;
          end
        end
        S_START: begin
          if (r_timer == START_LAST) begin
            r_state <= S_CONVERT;
            r_start <= 1'b0;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_CONVERT: begin
          if (w_eoc_rise) begin
            r_state <= S_ACCUM;
            r_timer <= '0;
          end else if (r_timer == TIMEOUT_LAST) begin
            r_timeout_err <= 1'b1;
            r_state       <= S_WAIT;
            // Start one below zero: with no ACCUM clock on this path, the
            // extra WAIT clock keeps the next request PERIOD clocks away.
            r_timer       <= '1;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_ACCUM: begin
          r_state <= S_WAIT;
          r_timer <= '0;
        end
        S_WAIT: begin
          if (r_timer == WAIT_LAST) begin
            r_timer <= '0;
            if (enable) begin
              r_state <= S_START;
              r_start <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_start <= 1'b0;
          r_timer <= '0;
        end
      endcase
    end
  end

  // ---- stage p0: sample capture on the eoc edge
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sample_p0 <= '0;
    end else if (w_capture) begin
      r_sample_p0 <= adc_value;
    end
  end

  // ---- stage p1: circular buffer write and running-sum update
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sum_p1    <= '0;
      r_wr_ptr    <= '0;
      r_fill      <= '0;
      r_strobe_p1 <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_strobe_p1 <= 1'b0;
      if (r_state == S_ACCUM) begin
        r_buf[r_wr_ptr] <= r_sample_p0;
        r_sum_p1        <= r_sum_p1 + SUM_W'(r_sample_p0) - SUM_W'(r_buf[r_wr_ptr]);
        r_wr_ptr        <= r_wr_ptr + LOG2_DEPTH'(1);
        if (r_fill != FILL_FULL) begin
          r_fill <= r_fill + (LOG2_DEPTH + 1)'(1);
        end
        r_strobe_p1 <= 1'b1;
      end
    end
  end

  // ---- stage p2: registered average and window-full flag
  always_ff @(posedge clock) begin
    if (reset) begin
      r_avg_p2 <= '0;
      r_vld_p2 <= 1'b0;
    end else begin
      r_avg_p2 <= f_avg(r_sum_p1);
      r_vld_p2 <= (r_fill == FILL_FULL);
    end
  end

`ifdef ADC_MINMAX_EN
  logic [WIDTH-1:0] r_min_p2;
  logic [WIDTH-1:0] r_max_p2;

  // Peak-hold of captured samples, one clock behind the sample strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_min_p2 <= '1;
      r_max_p2 <= '0;
    end else if (r_strobe_p1) begin
      if (r_sample_p0 < r_min_p2) r_min_p2 <= r_sample_p0;
      if (r_sample_p0 > r_max_p2) r_max_p2 <= r_sample_p0;
    end
  end

  assign min_val = r_min_p2;
  assign max_val = r_max_p2;
`endif

  assign adc_start     = r_start;
  assign avg           = r_avg_p2;
  assign avg_valid     = r_vld_p2;
  assign sample_strobe = r_strobe_p1;
  assign timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_adc_avg_filter.sv
// Directed testbench for adc_avg_filter with a small SAR handshake driver.
module tb_adc_avg_filter;

  localparam int WIDTH        = 8;
  localparam int LOG2_DEPTH   = 3;
  localparam int PERIOD       = 10;
  localparam int START_CYCLES = 4;
  localparam int TIMEOUT      = 20;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic [WIDTH-1:0] adc_value = '0;
  logic             adc_eoc = 1'b0;
  logic             adc_start;
  logic [WIDTH-1:0] avg;
  logic             avg_valid;
  logic             sample_strobe;
  logic             timeout_err;
`ifdef ADC_MINMAX_EN
  logic [WIDTH-1:0] min_val;
  logic [WIDTH-1:0] max_val;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  adc_avg_filter #(
    .WIDTH(WIDTH), .LOG2_DEPTH(LOG2_DEPTH), .PERIOD(PERIOD),
    .START_CYCLES(START_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .adc_value(adc_value), .adc_eoc(adc_eoc), .adc_start(adc_start),
    .avg(avg), .avg_valid(avg_valid), .sample_strobe(sample_strobe),
    .timeout_err(timeout_err)
`ifdef ADC_MINMAX_EN
    , .min_val(min_val), .max_val(max_val)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Hold reset for one edge and verify every output sits at its reset value.
  task automatic do_reset();
    reset   = 1'b1;
    adc_eoc = 1'b0;
    step();
    check("rst_start",  adc_start,     0);
    check("rst_avg",    avg,           0);
    check("rst_vld",    avg_valid,     0);
    check("rst_strobe", sample_strobe, 0);
    check("rst_terr",   timeout_err,   0);
    reset = 1'b0;
  endtask

  // Answer one start request: wait for the request to end, raise eoc after
  // lat clocks, drop it once the strobe is seen, return after avg updates.
  task automatic sar_convert(input logic [7:0] val, input int lat);
    int n;
    n = 0;
    while (adc_start !== 1'b1 && n < 200) begin step(); n++; end
    if (n >= 200) begin check("start_wait", 0, 1); return; end
    n = 0;
    while (adc_start === 1'b1 && n < 200) begin step(); n++; end
    repeat (lat) step();
    adc_value = val;
    adc_eoc   = 1'b1;
    n = 0;
    while (sample_strobe !== 1'b1 && n < 50) begin step(); n++; end
    if (n >= 50) check("strobe_wait", 0, 1);
    adc_eoc = 1'b0;
    step();
  endtask

  task automatic run_constant_window(input string tag);
    for (int i = 0; i < 8; i++) begin
      sar_convert(8'h40, 2 + (i % 3));
      check({tag, "_avg"}, avg, 32'(8 * (i + 1)));
      check({tag, "_vld"}, avg_valid, (i == 7) ? 1 : 0);
    end
  endtask

  logic [7:0] ramp_exp [16] = '{8'h1F, 8'h3F, 8'h5F, 8'h7F, 8'h9F, 8'hBF, 8'hDF, 8'hFF,
                                8'hDF, 8'hBF, 8'h9F, 8'h7F, 8'h5F, 8'h3F, 8'h1F, 8'h00};

  initial begin
    int n;
    int n_hi;
    int n_str;
    int n_req;

    step();
    enable = 1'b1;
    do_reset();

    // Constant 0x40 input fills the window from a zeroed buffer.
    run_constant_window("t1");

    // Reset during CONVERT, coinciding with an eoc edge: reset wins.
    n = 0;
    while (adc_start !== 1'b1 && n < 200) begin step(); n++; end
    n = 0;
    while (adc_start === 1'b1 && n < 200) begin step(); n++; end
    adc_value = 8'hAA;
    adc_eoc   = 1'b1;
    reset     = 1'b1;
    step();
    check("mid_rst_start",  adc_start,     0);
    check("mid_rst_avg",    avg,           0);
    check("mid_rst_vld",    avg_valid,     0);
    check("mid_rst_strobe", sample_strobe, 0);
    reset   = 1'b0;
    adc_eoc = 1'b0;
    step();
    check("mid_rst_nostrobe", sample_strobe, 0);
    run_constant_window("t4");

    // Full-scale window followed by zeros.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      sar_convert((i < 8) ? 8'hFF : 8'h00, 1);
      check("ramp_avg", avg, ramp_exp[i]);
    end

    // Timeout: eoc never rises.
    do_reset();
    n = 0;
    while (adc_start !== 1'b1 && n < 200) begin step(); n++; end
    n_hi = 0;
    while (adc_start === 1'b1 && n_hi < 200) begin step(); n_hi++; end
    check("to_start_len", n_hi, START_CYCLES);
    n = 0;
    n_str = 0;
    while (timeout_err !== 1'b1 && n < 200) begin
      step(); n++;
      if (sample_strobe === 1'b1) n_str++;
    end
    check("to_latency", n, TIMEOUT);
    check("to_nostrobe", n_str, 0);
    n = 0;
    while (adc_start !== 1'b1 && n < 200) begin step(); n++; end
    check("to_restart", n, PERIOD);
    check("to_sticky", timeout_err, 1);
    do_reset();

    // Enable dropped during START: one sample, then park in IDLE.
    n = 0;
    while (adc_start !== 1'b1 && n < 200) begin step(); n++; end
    enable = 1'b0;
    n_hi = 0;
    while (adc_start === 1'b1 && n_hi < 200) begin step(); n_hi++; end
    check("en_start_len", n_hi, START_CYCLES);
    repeat (3) step();
    adc_value = 8'h80;
    adc_eoc   = 1'b1;
    n = 0;
    n_str = 0;
    while (sample_strobe !== 1'b1 && n < 50) begin step(); n++; end
    if (sample_strobe === 1'b1) n_str++;
    adc_eoc = 1'b0;
    check("en_one_strobe", n_str, 1);
    n_req = 0;
    for (int i = 0; i < 3 * PERIOD + TIMEOUT; i++) begin
      step();
      if (adc_start === 1'b1) n_req++;
      if (sample_strobe === 1'b1) n_str++;
    end
    check("en_no_request", n_req, 0);
    check("en_strobes", n_str, 1);
    check("en_avg", avg, 8'h10);
    // Re-enable keeps the buffer contents.
    enable = 1'b1;
    sar_convert(8'h80, 2);
    check("reen_avg", avg, 8'h20);
    check("reen_vld", avg_valid, 0);

`ifdef ADC_MINMAX_EN
    do_reset();
    check("mm_rst_min", min_val, 8'hFF);
    check("mm_rst_max", max_val, 8'h00);
    sar_convert(8'h10, 1);
    sar_convert(8'h90, 1);
    sar_convert(8'h05, 1);
    check("mm_min", min_val, 8'h05);
    check("mm_max", max_val, 8'h90);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog");
  end

endmodule
